// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the scratch-memory arbiter.
package mem_arb_pkg;

    localparam int MAX_REQ = 4;
    localparam int IDXW = 2;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INC   = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } fsm_e;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
    } pick_t;

    // First valid index at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDXW-1:0]    ptr,
        input int                 n
    );
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !r.found && valid[j]) begin
                r.found = 1'b1;
                r.idx   = IDXW'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Request/response bundle between requesters and the memory arbiter.
interface mem_rr_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 2,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [2*NREQ-1:0]  req_op;
    logic [AW*NREQ-1:0] req_addr;
    logic [DW*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic [31:0]        grant_count;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, grant_count
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, grant_count
    );
endinterface

// File: rtl/mem_rr_arbiter_picker.sv
// Combinational round-robin priority select.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   idx,
    output logic            found
);
    pick_t pick;

    assign pick  = rr_pick(MAX_REQ'(valid), IDXW'(ptr), NREQ);
    assign found = pick.found;
    assign idx   = PW'(pick.idx);
endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one preloaded scratch memory,
// with READ, WRITE and single-cycle read-modify-write INC.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int          NREQ      = 2,
    parameter  int          DEPTH     = 4,
    parameter  int          DW        = 8,
    parameter  int unsigned INIT_BASE = 32'h10,
    localparam int          AW        = $clog2(DEPTH),
    localparam int          PW        = $clog2(NREQ)
) (
    input logic            clk,
    input logic            rst,
    mem_rr_arbiter_if.slave bus
);
    typedef logic [DEPTH-1:0][DW-1:0] mem_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = DW'(INIT_BASE * (i + 1));
        return m;
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Power-up contents only; reset deliberately leaves memory alone.
    mem_t mem = init_mem();

    fsm_e            state_q, state_d;
    logic [PW-1:0]   ptr_q, win, rmw_idx;
    logic            found, grant;
    op_e             win_op;
    logic [AW-1:0]   win_addr, rmw_addr;
    logic [DW-1:0]   win_wdata, win_rd, rmw_rd, rdata_q;
    logic [NREQ-1:0] win_oh, rsp_q;
    logic [31:0]     count_q;
    logic [NREQ-1:0] ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr_q),
        .idx   (win),
        .found (found)
    );

    assign win_op    = op_e'(bus.req_op[int'(win)*2 +: 2]);
    assign win_addr  = bus.req_addr[int'(win)*AW +: AW];
    assign win_wdata = bus.req_wdata[int'(win)*DW +: DW];
    assign win_rd    = in_range(win_addr) ? mem[win_addr] : '0;
    assign rmw_rd    = in_range(rmw_addr) ? mem[rmw_addr] : '0;
    assign win_oh    = NREQ'(1) << win;
    assign grant     = found && (state_q == S_IDLE) && !rst;

    always_comb begin
        state_d   = state_q;
        ready     = '0;
        rsp_valid = '0;
        rsp_rdata = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                rsp_valid = rsp_q;
                if (grant) begin
                    ready = win_oh;
                    if (win_op == OP_INC) state_d = S_RMW;
                end
            end
            S_RMW: begin
                rsp_valid = NREQ'(1) << rmw_idx;
                rsp_rdata = rmw_rd;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset in the RMW cycle suppresses the response too.
        if (rst) begin
            ready     = '0;
            rsp_valid = '0;
            rsp_rdata = '0;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rdata   = rsp_rdata;
    assign bus.grant_count = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (grant && win_op == OP_WRITE && in_range(win_addr))
                mem[win_addr] <= win_wdata;
            if (state_q == S_RMW && in_range(rmw_addr))
                mem[rmw_addr] <= rmw_rd + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            count_q  <= '0;
            rsp_q    <= '0;
            rdata_q  <= '0;
            rmw_idx  <= '0;
            rmw_addr <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= '0;
            if (state_q == S_RMW) rdata_q <= rmw_rd;
            if (grant) begin
                ptr_q   <= (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
                count_q <= count_q + 32'd1;
                case (win_op)
                    OP_WRITE: begin
                        rsp_q   <= win_oh;
                        rdata_q <= win_wdata;
                    end
                    OP_INC: begin
                        rmw_idx  <= win;
                        rmw_addr <= win_addr;
                    end
                    default: begin
                        rsp_q   <= win_oh;
                        rdata_q <= win_rd;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: preload, round-robin, hazards,
// INC wrap, reset during RMW and idle stability.
module tb_mem_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.NREQ(2), .AW(2), .DW(8)) bus ();

    mem_rr_arbiter #(
        .NREQ(2), .DEPTH(4), .DW(8), .INIT_BASE(32'h10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [1:0] addr, input logic [7:0] wd);
        bus.req_valid[i]          = v;
        bus.req_op[i*2 +: 2]      = op;
        bus.req_addr[i*2 +: 2]    = addr;
        bus.req_wdata[i*8 +: 8]   = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_d;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        tick();
        chk("rst_count", bus.grant_count, 32'd0);
        chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        set_req(0, 1'b1, 2'd0, 2'd0, 8'h00);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 2'd0, 2'd0, 8'h00);

        // preload readback by requester 0
        for (int a = 0; a < 4; a++) begin
            set_req(0, 1'b1, 2'd0, 2'(a), 8'h00);
            #1;
            chk("pre_ready", 32'(bus.req_ready), 32'd1);
            tick();
            exp_d = 8'((a + 1) * 16);
            chk("pre_rspv", 32'(bus.rsp_valid), 32'd1);
            chk("pre_rdata", 32'(bus.rsp_rdata), 32'(exp_d));
        end
        set_req(0, 1'b0, 2'd0, 2'd0, 8'h00);
        chk("pre_count", bus.grant_count, 32'd4);

        // round robin from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 2'd0, 2'd0, 8'h00);
        set_req(1, 1'b1, 2'd0, 2'd1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("rr_rspv", 32'(bus.rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_rdata", 32'(bus.rsp_rdata),
                (k % 2 == 0) ? 32'h10 : 32'h20);
        end
        set_req(0, 1'b0, 2'd0, 2'd0, 8'h00);
        set_req(1, 1'b0, 2'd0, 2'd0, 8'h00);
        chk("rr_count", bus.grant_count, 32'd4);

        // write then read same address
        set_req(1, 1'b1, 2'd1, 2'd2, 8'hAB);
        #1;
        chk("wr_ready", 32'(bus.req_ready), 32'd2);
        tick();
        chk("wr_rspv", 32'(bus.rsp_valid), 32'd2);
        chk("wr_rdata", 32'(bus.rsp_rdata), 32'hAB);
        set_req(1, 1'b0, 2'd0, 2'd0, 8'h00);
        set_req(0, 1'b1, 2'd0, 2'd2, 8'h00);
        #1;
        chk("rd_ready", 32'(bus.req_ready), 32'd1);
        tick();
        chk("rd_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("rd_rdata", 32'(bus.rsp_rdata), 32'hAB);

        // INC wrap FF -> 00
        set_req(0, 1'b1, 2'd1, 2'd3, 8'hFF);
        tick();
        chk("wff_rdata", 32'(bus.rsp_rdata), 32'hFF);
        set_req(0, 1'b1, 2'd2, 2'd3, 8'h00);
        #1;
        chk("inc_ready", 32'(bus.req_ready), 32'd1);
        tick();
        set_req(0, 1'b1, 2'd0, 2'd3, 8'h00);
        #1;
        chk("rmw_ready", 32'(bus.req_ready), 32'd0);
        chk("rmw_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("rmw_rdata", 32'(bus.rsp_rdata), 32'hFF);
        tick();
        chk("post_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("post_ready", 32'(bus.req_ready), 32'd1);
        tick();
        chk("wrap_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("wrap_rdata", 32'(bus.rsp_rdata), 32'h00);
        set_req(0, 1'b0, 2'd0, 2'd0, 8'h00);
        chk("inc_count", bus.grant_count, 32'd9);

        // reset during RMW aborts increment
        set_req(0, 1'b1, 2'd2, 2'd1, 8'h00);
        #1;
        chk("ri_ready", 32'(bus.req_ready), 32'd1);
        tick();
        set_req(0, 1'b0, 2'd0, 2'd0, 8'h00);
        rst = 1'b1;
        #1;
        chk("ri_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("ri_ready0", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        chk("ri_count", bus.grant_count, 32'd0);
        set_req(0, 1'b1, 2'd0, 2'd1, 8'h00);
        #1;
        chk("ri_rd_ready", 32'(bus.req_ready), 32'd1);
        tick();
        chk("ri_rd_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("ri_rd_rdata", 32'(bus.rsp_rdata), 32'h20);
        set_req(0, 1'b0, 2'd0, 2'd0, 8'h00);

        // idle: nothing moves
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_rspv", 32'(bus.rsp_valid), 32'd0);
        end
        chk("idle_count", bus.grant_count, 32'd1);
        set_req(0, 1'b1, 2'd0, 2'd0, 8'h00);
        set_req(1, 1'b1, 2'd0, 2'd1, 8'h00);
        #1;
        chk("idle_ptr", 32'(bus.req_ready), 32'd2);
        tick();
        chk("idle_rd1", 32'(bus.rsp_rdata), 32'h20);
        set_req(1, 1'b0, 2'd0, 2'd0, 8'h00);
        set_req(0, 1'b1, 2'd0, 2'd2, 8'h00);
        tick();
        chk("idle_rd2v", 32'(bus.rsp_valid), 32'd1);
        chk("idle_rd2", 32'(bus.rsp_rdata), 32'hAB);
        set_req(0, 1'b0, 2'd0, 2'd0, 8'h00);
        chk("end_count", bus.grant_count, 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one single-port DEPTH x DW byte memory between NREQ requesters using round-robin arbitration.
- Supported ops: READ, WRITE, and atomic INC (read-modify-write, memory word +1).
- Memory is preloaded once at time zero and is not cleared by reset; arbiter and counter state are.
- Sits in front of small scratch memories in the simulator test designs; it exercises initial blocks, packed arrays and FSMs.

Parameters:
- NREQ, 2, number of requesters (2..4)
- DEPTH, 4, memory words; AW = $clog2(DEPTH)
- DW, 8, data width
- INIT_BASE, 8'h10, preload value of word 0; word i preloads INIT_BASE*(i+1) truncated to DW (10,20,30,40 by default)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NREQ  request pending, one bit per requester
- req_op  input  2*NREQ  per-requester op: 0 READ, 1 WRITE, 2 INC, 3 reserved (treated as READ)
- req_addr  input  AW*NREQ  per-requester word address
- req_wdata  input  DW*NREQ  per-requester write data
- req_ready  output  NREQ  one-hot grant, combinational from state
- rsp_valid  output  NREQ  one-hot response strobe
- rsp_rdata  output  DW  read data; for INC, the pre-increment value
- grant_count  output  32  total accepted requests since reset

Behaviour:
- Handshake
  - Transfer occurs when req_valid[i] and req_ready[i] are both high.
  - Requester holds op/addr/wdata stable while valid and not ready.
  - At most one req_ready bit is high per cycle.
- Arbitration
  - rr_ptr holds the highest-priority index.
  - Winner is the first valid index at or after rr_ptr, wrapping modulo NREQ.
  - After a grant, rr_ptr = winner+1 mod NREQ.
  - No valid requests: rr_ptr unchanged.
- FSM states: IDLE, RMW.
  - IDLE: grants allowed.
  - READ: rsp_valid[i]=1 and rsp_rdata=mem[addr] in the next cycle. Stay IDLE.
  - WRITE: mem[addr] <= wdata at the grant edge. rsp_valid[i]=1 next cycle; rsp_rdata holds the written value. Stay IDLE.
  - INC: latch winner index and addr, go to RMW.
  - RMW (exactly 1 cycle, req_ready all 0): mem[addr] <= mem[addr]+1 (DW-bit wrap, FF->00). rsp_rdata = old value, rsp_valid[i]=1 during this cycle. Return to IDLE.
- Latency: READ/WRITE response 1 cycle after grant. INC response 1 cycle after grant, and blocks the next grant for 1 cycle. Back-to-back READ/WRITE grants every cycle.
- Hazards: a READ granted in the cycle after a WRITE or INC to the same address returns the updated value, since memory updates on the edge.
- grant_count: +1 per accepted transfer, 32-bit wrap.
- Reset (rst high at edge)
  - State: FSM=IDLE, rr_ptr=0, grant_count=0.
  - Outputs: rsp_valid=0, rsp_rdata=0, req_ready=0 during the reset cycle.
  - Memory contents are preserved.
  - Reset during RMW aborts the increment: memory unchanged, no response.
- Out-of-range addresses cannot occur for power-of-2 DEPTH. Otherwise addresses >= DEPTH read 0 and ignore writes, but still respond.

Decomposition:
- Package mem_arb_pkg:
  - op_e enum (OP_READ, OP_WRITE, OP_INC, OP_RSVD)
  - fsm_e enum (S_IDLE, S_RMW)
  - function rr_pick(valid, ptr) returning the winner index and a found flag
- Sub-module rr_picker: combinational round-robin priority select, reused by other arbiters.
- Memory and initial preload stay in the top module.

Test Plan:
- Preload: rst 1 cycle, then requester 0 READs addr 0..3 -> rsp_rdata 10,20,30,40, each 1 cycle after grant; grant_count=4.
- Round-robin: both requesters valid continuously with READs -> grants alternate 0,1,0,1 over 4 cycles; grant_count=4.
- Write-then-read: req1 WRITE addr2=8'hAB, next cycle req0 READ addr2 -> rdata AB.
- INC wrap: WRITE addr3=FF, then INC addr3 -> rsp_rdata FF, following READ -> 00. req_ready is all-zero in the RMW cycle.
- Reset mid-RMW: issue INC addr1 (value 20), assert rst in the RMW cycle -> no rsp_valid, READ addr1 -> 20, grant_count restarts from 0.
- Idle: no valid for 5 cycles -> rr_ptr, grant_count and memory unchanged; rsp_valid stays 0.
